sm_addsub_param: RTL and testbench
==================================

// Module: sm_addsub_param
// PURPOSE
//  Parametrised sign-magnitude adder/subtractor with a start/finish handshake.
//  Successor to the fixed 16-bit add unit. Adds WIDTH, an overflow flag, optional saturation,
//  canonical +0 output and a busy indicator.
//  Serves the matrix-multiplier datapath: accumulation of partial products and operand pre-scaling.
// PARAMETERS
//  WIDTH     16  total word width; bit WIDTH-1 = sign, bits WIDTH-2:0 = magnitude (MAG=WIDTH-1); WIDTH>=3
//  SATURATE  0   0: magnitude wraps on overflow; 1: magnitude clamps to all-ones, sign kept
// PORTS
//  clk       in   1      clock, rising edge
//  nRST      in   1      reset, synchronous, active-low
//  INn1      in   WIDTH  operand A, sign-magnitude
//  INn2      in   WIDTH  operand B, sign-magnitude
//  sub       in   1      1: A-B (B sign inverted), 0: A+B
//  start     in   1      level request; operands/sub sampled on the accepting edge
//  out       out  WIDTH  registered result, sign-magnitude
//  overflow  out  1      registered; result magnitude exceeded 2^MAG-1
//  busy      out  1      high in LOAD, ADD and FIN
//  finish    out  1      registered; high in FIN, result valid
// BEHAVIOUR
//  Reset: nRST=0 at a clk edge -> state=IDLE, out=0, overflow=0, finish=0, busy=0.
//   Reset mid-operation aborts the operation; finish does not pulse.
//  FSM IDLE->LOAD->ADD->FIN->IDLE:
//   IDLE: start=1 at edge k -> LOAD. INn1, INn2 and sub are captured at edge k.
//   LOAD: one cycle; align operands, compute sB=INn2[W-1]^sub, diff=sA^sB -> ADD at edge k+1.
//   ADD: one cycle; MAG-bit add (diff=0) or subtract (diff=1).
//     Edge k+2 -> FIN; out, overflow and finish=1 are registered on this edge.
//   FIN: hold out, overflow and finish until start=0.
//     The edge that sees start=0 -> IDLE and clears finish. out and overflow keep their values.
//  Latency: finish high 3 edges after start is accepted.
//   Minimum turnaround: start must be seen low for 1 edge before the next accept.
//  start dropped during LOAD/ADD: ignored, operation completes. In FIN with start=0, finish is high exactly 1 cycle.
//  Input changes after the accept edge are ignored. Inputs are a don't-care outside IDLE.
//  Arithmetic:
//   diff=0: mag = |A|+|B| (MAG+1 bits). Carry out -> overflow=1.
//     SATURATE=0: out mag = low MAG bits. SATURATE=1: out mag = all ones. Sign = sA.
//   diff=1: |A|>=|B| -> mag=|A|-|B|, sign=sA. Otherwise mag=|B|-|A|, sign=sB. overflow=0 always.
//   -0 input is treated as 0.
//   Zero magnitude result -> sign forced to 0 (never emit -0), including a wrapped overflow result.
// TESTING (WIDTH=16 unless stated)
//  1. INn1=0x0005, INn2=0x0003, sub=0, start 1 -> 3 edges later out=0x0008, overflow=0, finish=1, busy=1.
//  2. INn1=0x0005, INn2=0x0009, sub=1 -> out=0x8004. INn1=0x8002, INn2=0x0007, sub=0 -> out=0x0005.
//  3. INn1=0x7FFF, INn2=0x0001, sub=0: SATURATE=0 -> out=0x0000, overflow=1. SATURATE=1 -> out=0x7FFF, overflow=1.
//  4. INn1=0x8003, INn2=0x0003, sub=0 -> out=0x0000 (not 0x8000). INn1=0x8000, INn2=0x0000, sub=1 -> out=0x0000.
//  5. nRST=0 for 1 edge while in ADD -> next cycle out=0, finish=0, busy=0, no finish pulse.
//     start still high -> new operation accepted on the following edge.
//  6. start held high through FIN -> finish and out stable for 10 cycles, no re-accept.
//     start as a 1-cycle pulse -> finish high exactly 1 cycle, then IDLE.
//     WIDTH=8 run of case 3 with 0x7F+0x01 -> out=0x00, overflow=1.

Source files
------------

// File: rtl/sm_addsub_param.sv
// Sign-magnitude add/sub, 4-state handshake: result and finish registered 3 edges after start is accepted.
// finish holds in FIN until start drops; start and operands are ignored outside IDLE.
module sm_addsub_param #(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [WIDTH-1:0] INn1,
  input  logic [WIDTH-1:0] INn2,
  input  logic             sub,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             busy,
  output logic             finish
);

  localparam int MAG = WIDTH - 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] in1_q, in1_d, in2_q, in2_d;
  logic             sub_q, sub_d;
  logic [MAG-1:0]   ma_q, ma_d, mb_q, mb_d;
  logic             sa_q, sa_d, sb_q, sb_d, diff_q, diff_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d, fin_q, fin_d;

  logic [MAG:0]     sum;
  logic [MAG-1:0]   res_mag;
  logic             res_sign;
  logic             a_ge_b;

  always_comb begin
    sum      = {1'b0, ma_q} + {1'b0, mb_q};
    a_ge_b   = (ma_q >= mb_q);
    res_mag  = '0;
    res_sign = sa_q;
    if (!diff_q) begin
      res_mag = sum[MAG-1:0];
      if (SATURATE && sum[MAG]) res_mag = '1;
    end else if (a_ge_b) begin
      res_mag = ma_q - mb_q;
    end else begin
      res_mag  = mb_q - ma_q;
      res_sign = sb_q;
    end
    // A zero magnitude always leaves as +0, wrapped overflow included.
    if (res_mag == '0) res_sign = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    sub_d   = sub_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    diff_d  = diff_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    fin_d   = fin_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          in1_d   = INn1;
          in2_d   = INn2;
          sub_d   = sub;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Signs of zero-magnitude operands are cleared so -0 behaves as +0.
        ma_d    = in1_q[MAG-1:0];
        mb_d    = in2_q[MAG-1:0];
        sa_d    = in1_q[MAG] & (|in1_q[MAG-1:0]);
        sb_d    = (in2_q[MAG] ^ sub_q) & (|in2_q[MAG-1:0]);
        diff_d  = sa_d ^ sb_d;
        state_d = S_ADD;
      end
      S_ADD: begin
        out_d   = {res_sign, res_mag};
        ovf_d   = ~diff_q & sum[MAG];
        fin_d   = 1'b1;
        state_d = S_FIN;
      end
      S_FIN: begin
        if (!start) begin
          fin_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      in1_q   <= '0;
      in2_q   <= '0;
      sub_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      diff_q  <= 1'b0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      sub_q   <= sub_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      diff_q  <= diff_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      fin_q   <= fin_d;
    end
  end

  assign out      = out_q;
  assign overflow = ovf_q;
  assign finish   = fin_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sm_addsub_param.sv
// Directed bench for sm_addsub_param: 16-bit wrap, 16-bit saturating and 8-bit wrap instances share control.
module tb_sm_addsub_param;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] in1, in2;
  logic [7:0]  in8_1, in8_2;
  logic        sub_i, start;

  logic [15:0] out0, out1;
  logic [7:0]  out2;
  logic        ov0, ov1, ov2, busy0, busy1, busy2, fin0, fin1, fin2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sm_addsub_param #(.WIDTH(16), .SATURATE(1'b0)) dut0 (
    .clk(clk), .nRST(nrst), .INn1(in1), .INn2(in2), .sub(sub_i), .start(start),
    .out(out0), .overflow(ov0), .busy(busy0), .finish(fin0));

  sm_addsub_param #(.WIDTH(16), .SATURATE(1'b1)) dut1 (
    .clk(clk), .nRST(nrst), .INn1(in1), .INn2(in2), .sub(sub_i), .start(start),
    .out(out1), .overflow(ov1), .busy(busy1), .finish(fin1));

  sm_addsub_param #(.WIDTH(8), .SATURATE(1'b0)) dut2 (
    .clk(clk), .nRST(nrst), .INn1(in8_1), .INn2(in8_2), .sub(sub_i), .start(start),
    .out(out2), .overflow(ov2), .busy(busy2), .finish(fin2));

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accept on the next edge and wait until the result edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    in1 = a; in2 = b; sub_i = s; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_op();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; start = 1'b0; sub_i = 1'b0;
    in1 = 16'h1111; in2 = 16'h2222; in8_1 = 8'h00; in8_2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out0 !== 16'h0000) begin errors++; $display("FAIL reset_out got %h want 0000", out0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ov0); end
    checks++; if (fin0 !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", fin0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_add();
    @(negedge clk);
    in1 = 16'h0005; in2 = 16'h0003; sub_i = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (fin0 !== 1'b0) begin errors++; $display("FAIL add_early_finish got %b want 0", fin0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL add_busy_mid got %b want 1", busy0); end
    @(posedge clk);
    #1;
    checks++; if (fin0 !== 1'b1) begin errors++; $display("FAIL add_finish got %b want 1", fin0); end
    checks++; if (out0 !== 16'h0008) begin errors++; $display("FAIL add_out got %h want 0008", out0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL add_ovf got %b want 0", ov0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL add_busy_fin got %b want 1", busy0); end
    release_op();
    checks++; if (fin0 !== 1'b0) begin errors++; $display("FAIL add_finish_clear got %b want 0", fin0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL add_busy_idle got %b want 0", busy0); end
    checks++; if (out0 !== 16'h0008) begin errors++; $display("FAIL add_out_kept got %h want 0008", out0); end
  endtask

  task automatic test_sub();
    launch(16'h0005, 16'h0009, 1'b1);
    checks++; if (out0 !== 16'h8004) begin errors++; $display("FAIL sub_neg got %h want 8004", out0); end
    release_op();
    launch(16'h8002, 16'h0007, 1'b0);
    checks++; if (out0 !== 16'h0005) begin errors++; $display("FAIL add_mixed got %h want 0005", out0); end
    release_op();
    launch(16'h8007, 16'h8002, 1'b1);
    checks++; if (out0 !== 16'h8005) begin errors++; $display("FAIL sub_negneg got %h want 8005", out0); end
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL sub_ovf got %b want 0", ov0); end
    release_op();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in1 = 16'h0010; in2 = 16'h0020; sub_i = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out0 !== 16'h0000) begin errors++; $display("FAIL rstmid_out got %h want 0000", out0); end
    checks++; if (fin0 !== 1'b0) begin errors++; $display("FAIL rstmid_finish got %b want 0", fin0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy0); end
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rstmid_reaccept got %b want 1", busy0); end
    @(posedge clk);
    #1;
    checks++; if (fin0 !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse got %b want 0", fin0); end
    @(posedge clk);
    #1;
    checks++; if (fin0 !== 1'b1) begin errors++; $display("FAIL rstmid_finish2 got %b want 1", fin0); end
    checks++; if (out0 !== 16'h0030) begin errors++; $display("FAIL rstmid_out2 got %h want 0030", out0); end
    release_op();
  endtask

  task automatic test_zero();
    launch(16'h8003, 16'h0003, 1'b0);
    checks++; if (out0 !== 16'h0000) begin errors++; $display("FAIL zero_cancel got %h want 0000", out0); end
    release_op();
    launch(16'h8000, 16'h0000, 1'b1);
    checks++; if (out0 !== 16'h0000) begin errors++; $display("FAIL zero_negzero got %h want 0000", out0); end
    release_op();
  endtask

  task automatic test_overflow();
    in8_1 = 8'h7F; in8_2 = 8'h01;
    launch(16'h7FFF, 16'h0001, 1'b0);
    checks++; if (out0 !== 16'h0000) begin errors++; $display("FAIL ovf_wrap_out got %h want 0000", out0); end
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL ovf_wrap_flag got %b want 1", ov0); end
    checks++; if (out1 !== 16'h7FFF) begin errors++; $display("FAIL ovf_sat_out got %h want 7fff", out1); end
    checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL ovf_sat_flag got %b want 1", ov1); end
    checks++; if (out2 !== 8'h00) begin errors++; $display("FAIL ovf_w8_out got %h want 00", out2); end
    checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL ovf_w8_flag got %b want 1", ov2); end
    release_op();
    launch(16'hFFFF, 16'h8001, 1'b0);
    checks++; if (out0 !== 16'h0000) begin errors++; $display("FAIL ovf_negwrap_zero got %h want 0000", out0); end
    checks++; if (out1 !== 16'hFFFF) begin errors++; $display("FAIL ovf_negsat got %h want ffff", out1); end
    release_op();
    launch(16'hFFFF, 16'h8002, 1'b0);
    checks++; if (out0 !== 16'h8001) begin errors++; $display("FAIL ovf_negwrap got %h want 8001", out0); end
    checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL ovf_negwrap_flag got %b want 1", ov0); end
    release_op();
    launch(16'h0001, 16'h0002, 1'b0);
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", ov0); end
    checks++; if (out1 !== 16'h0003) begin errors++; $display("FAIL sat_normal got %h want 0003", out1); end
    release_op();
  endtask

  task automatic test_hold();
    launch(16'h0005, 16'h0003, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++; if (fin0 !== 1'b1 || out0 !== 16'h0008 || busy0 !== 1'b1) begin
        errors++; $display("FAIL hold_cycle%0d got fin=%b out=%h busy=%b want 1 0008 1", i, fin0, out0, busy0);
      end
    end
    release_op();
    checks++; if (fin0 !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", fin0); end
  endtask

  task automatic test_pulse();
    @(negedge clk);
    in1 = 16'h0004; in2 = 16'h8001; sub_i = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; in1 = 16'h1234; in2 = 16'h7000; sub_i = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL pulse_busy got %b want 1", busy0); end
    @(posedge clk);
    #1;
    checks++; if (fin0 !== 1'b1) begin errors++; $display("FAIL pulse_finish got %b want 1", fin0); end
    checks++; if (out0 !== 16'h0003) begin errors++; $display("FAIL pulse_out got %h want 0003", out0); end
    @(posedge clk);
    #1;
    checks++; if (fin0 !== 1'b0) begin errors++; $display("FAIL pulse_one_cycle got %b want 0", fin0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL pulse_idle got %b want 0", busy0); end
    @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL pulse_no_reaccept got %b want 0", busy0); end
  endtask

  task automatic test_back_to_back();
    launch(16'h0100, 16'h0023, 1'b1);
    checks++; if (out0 !== 16'h00DD) begin errors++; $display("FAIL b2b_first got %h want 00dd", out0); end
    release_op();
    launch(16'h8010, 16'h8020, 1'b0);
    checks++; if (out0 !== 16'h8030) begin errors++; $display("FAIL b2b_second got %h want 8030", out0); end
    release_op();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_reset_mid();
    test_zero();
    test_overflow();
    test_hold();
    test_pulse();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
